// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing AHB signal bundle: request/lock inputs, address-phase
// transfer info and ready in; grant, owning master and lock flag out.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MASTER_W    = 2
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MASTER_W-1:0]    hmaster;
  logic                   hmastlock;

  // Requester / bus-fabric side
  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmastlock
  );

  // Arbiter side
  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with fixed-length burst hold and locked-sequence hold.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned MASTER_W       = 2,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOwn, StBurst, StLock} state_e;

  localparam logic [1:0]          TransIdle   = 2'd0;
  localparam logic [1:0]          TransNonseq = 2'd2;
  localparam logic [1:0]          TransSeq    = 2'd3;
  localparam logic [MASTER_W-1:0] DefIdx      = MASTER_W'(DEFAULT_MASTER);

  state_e              state_q, state_d;
  logic [MASTER_W-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0] master_q;
  logic                mastlock_q;
  logic [4:0]          cnt_q, cnt_d;
  logic [MASTER_W-1:0] winner;
  logic                any_req;
  logic [4:0]          burst_len;
  logic                lock_req;
  logic                rearb;

  // Remaining SEQ beats after the NONSEQ; zero marks SINGLE/INCR.
  always_comb begin
    burst_len = 5'd0;
    case (bus.hburst)
      3'd2, 3'd3: burst_len = 5'd3;
      3'd4, 3'd5: burst_len = 5'd7;
      3'd6, 3'd7: burst_len = 5'd15;
      default:    burst_len = 5'd0;
    endcase
  end

`ifdef AHB_ARB_ROUND_ROBIN_EN
  logic [MASTER_W-1:0] ptr_q;
  logic [MASTER_W-1:0] idx;

  always_comb begin
    winner  = DefIdx;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = MASTER_W'((32'(ptr_q) + i) % NUM_MASTERS);
      if (!any_req && bus.hbusreq[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ptr_q <= DefIdx;
    end else if (bus.hready && (grant_d != grant_q)) begin
      ptr_q <= grant_d;
    end
  end
`else
  always_comb begin
    winner  = DefIdx;
    any_req = |bus.hbusreq;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (bus.hbusreq[i[MASTER_W-1:0]]) winner = i[MASTER_W-1:0];
    end
  end
`endif

  assign lock_req = bus.hlock[grant_q] & bus.hbusreq[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rearb   = 1'b0;
    if (bus.hready) begin
      case (state_q)
        StIdle, StOwn: begin
          if (lock_req) begin
            state_d = StLock;
            cnt_d   = '0;
          end else if (bus.htrans == TransNonseq && burst_len != 5'd0) begin
            state_d = StBurst;
            cnt_d   = burst_len;
          end else begin
            rearb = 1'b1;
          end
        end
        StBurst: begin
          // A lock takes over the burst; counter expiry then no longer matters.
          if (lock_req) begin
            state_d = StLock;
            cnt_d   = '0;
          end else if (bus.htrans == TransIdle || bus.htrans == TransNonseq) begin
            rearb = 1'b1;
          end else if (bus.htrans == TransSeq) begin
            if (cnt_q <= 5'd1) rearb = 1'b1;
            else               cnt_d = cnt_q - 5'd1;
          end
        end
        StLock: begin
          // Release edge keeps the grant; the following ready edge rearbitrates.
          if (!bus.hlock[grant_q]) state_d = StOwn;
        end
        default: state_d = StIdle;
      endcase
      if (rearb) begin
        cnt_d   = '0;
        grant_d = any_req ? winner : DefIdx;
        state_d = any_req ? StOwn : StIdle;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= StIdle;
      grant_q    <= DefIdx;
      master_q   <= DefIdx;
      mastlock_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      if (bus.hready) begin
        master_q   <= grant_q;
        mastlock_q <= bus.hlock[grant_q];
      end
    end
  end

  always_comb begin
    bus.hgrant          = '0;
    bus.hgrant[grant_q] = 1'b1;
  end

  assign bus.hmaster   = master_q;
  assign bus.hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_ahb_arbiter;
  localparam int N   = 4;
  localparam int W   = 2;
  localparam int DEF = 0;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  ahb_arbiter_if #(.NUM_MASTERS(N), .MASTER_W(W)) bus_if ();

  ahb_arbiter #(.NUM_MASTERS(N), .MASTER_W(W), .DEFAULT_MASTER(DEF)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus_if.slave)
  );

  always #5 hclk = ~hclk;

  // Behavioural model: grant index, owner, lock flag, SEQ beats still owed
  int m_grant, m_owner, m_beats;
  bit m_mlock, m_locked;

  function automatic int beats_of(logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic int pick(logic [N-1:0] req, int last);
`ifdef AHB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (req[(last + k) % N]) return (last + k) % N;
`else
    for (int k = 0; k < N; k++) if (req[k]) return k;
`endif
    return DEF;
  endfunction

  int n_grant, n_beats;
  bit n_locked, rearb;
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_grant <= DEF; m_owner <= DEF; m_mlock <= 1'b0; m_locked <= 1'b0; m_beats <= 0;
    end else if (bus_if.hready) begin
      n_grant = m_grant; n_beats = m_beats; n_locked = m_locked; rearb = 1'b0;
      if (m_locked) begin
        if (!bus_if.hlock[m_grant]) n_locked = 1'b0;
      end else if (bus_if.hlock[m_grant] && bus_if.hbusreq[m_grant]) begin
        n_locked = 1'b1; n_beats = 0;
      end else if (m_beats > 0) begin
        if (bus_if.htrans == 2'd0 || bus_if.htrans == 2'd2) rearb = 1'b1;
        else if (bus_if.htrans == 2'd3) begin
          n_beats = m_beats - 1;
          if (n_beats == 0) rearb = 1'b1;
        end
      end else if (bus_if.htrans == 2'd2 && beats_of(bus_if.hburst) > 1) begin
        n_beats = beats_of(bus_if.hburst) - 1;
      end else begin
        rearb = 1'b1;
      end
      if (rearb) begin
        n_beats = 0;
        n_grant = pick(bus_if.hbusreq, m_grant);
      end
      m_owner  <= m_grant;
      m_mlock  <= bus_if.hlock[m_grant];
      m_grant  <= n_grant;
      m_beats  <= n_beats;
      m_locked <= n_locked;
    end
  end

  // Every-cycle comparison against the model
  logic [N-1:0] exp_grant;
  always @(negedge hclk) begin
    if (chk_en) begin
      exp_grant = '0;
      exp_grant[m_grant] = 1'b1;
      n_checks++;
      if (bus_if.hgrant !== exp_grant || bus_if.hmaster !== W'(m_owner) ||
          bus_if.hmastlock !== m_mlock) begin
        n_fail++;
        $display("FAIL model t=%0t: got grant=%b master=%0d lock=%b, want grant=%b master=%0d lock=%b",
                 $time, bus_if.hgrant, bus_if.hmaster, bus_if.hmastlock,
                 exp_grant, m_owner, m_mlock);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge hclk);
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu);
    bus_if.hbusreq = req; bus_if.hlock = lk; bus_if.htrans = tr; bus_if.hburst = bu;
  endtask

  logic [N-1:0] rq, lk;
  int r;

  initial begin
    bus_if.hready = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0);
    repeat (3) cyc();
    chk("reset_grant", bus_if.hgrant, 4'b0001);
    chk("reset_master", bus_if.hmaster, 0);
    chk("reset_lock", bus_if.hmastlock, 0);
    chk_en = 1'b1;
    hresetn = 1'b1;

    // No requests: default master parked for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("park", {bus_if.hgrant, 2'(bus_if.hmaster), bus_if.hmastlock}, {4'b0001, 2'd0, 1'b0});
    end

    // Master 1 INCR4 with master 2 waiting
    drive(4'b0010, 4'b0000, 2'd0, 3'd0);
    cyc(); chk("incr4_grant1", bus_if.hgrant, 4'b0010);
    cyc(); chk("incr4_owner1", bus_if.hmaster, 1);
    drive(4'b0110, 4'b0000, 2'd2, 3'd3);
    cyc(); chk("incr4_beat1", bus_if.hgrant, 4'b0010);
    bus_if.htrans = 2'd3;
    cyc(); chk("incr4_beat2", bus_if.hgrant, 4'b0010);
    cyc(); chk("incr4_beat3", bus_if.hgrant, 4'b0010);
    bus_if.hbusreq = 4'b0100;
    cyc(); chk("incr4_handover", bus_if.hgrant, 4'b0100);
    chk("incr4_last_owner", bus_if.hmaster, 1);
    bus_if.htrans = 2'd0;
    cyc(); chk("incr4_new_owner", bus_if.hmaster, 2);

    // Same burst with wait states and a BUSY
    drive(4'b0010, 4'b0000, 2'd0, 3'd0);
    cyc(); cyc(); chk("ws_owner1", bus_if.hmaster, 1);
    drive(4'b0110, 4'b0000, 2'd2, 3'd3);
    cyc();
    bus_if.htrans = 2'd3; bus_if.hready = 1'b0;
    cyc(); cyc(); chk("ws_hold_wait", bus_if.hgrant, 4'b0010);
    bus_if.hready = 1'b1;
    cyc(); chk("ws_beat2", bus_if.hgrant, 4'b0010);
    bus_if.htrans = 2'd1;
    cyc(); chk("ws_busy", bus_if.hgrant, 4'b0010);
    bus_if.htrans = 2'd3;
    cyc(); chk("ws_beat3", bus_if.hgrant, 4'b0010);
    bus_if.hbusreq = 4'b0100;
    cyc(); chk("ws_handover", bus_if.hgrant, 4'b0100);
    bus_if.htrans = 2'd0;
    cyc();

    // Locked sequence from master 3 against full contention
    drive(4'b1000, 4'b1000, 2'd0, 3'd0);
    cyc(); chk("lock_grant3", bus_if.hgrant, 4'b1000);
    cyc(); chk("lock_mastlock", bus_if.hmastlock, 1);
    bus_if.hbusreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lock_hold", {bus_if.hgrant, bus_if.hmastlock}, {4'b1000, 1'b1});
    end
    bus_if.hlock = 4'b0000;
    cyc(); chk("lock_tail", {bus_if.hgrant, bus_if.hmastlock}, {4'b1000, 1'b0});
    cyc(); chk("lock_release", bus_if.hgrant, 4'b0001);

    // SINGLE transfers under full contention
    drive(4'b1111, 4'b0000, 2'd2, 3'd0);
    for (int i = 0; i < 8; i++) begin
      cyc();
`ifdef AHB_ARB_ROUND_ROBIN_EN
      chk("single_master", bus_if.hmaster, i % 4);
`else
      chk("single_master", bus_if.hmaster, 0);
`endif
    end

    // Reset in the middle of an INCR8
    drive(4'b0010, 4'b0000, 2'd0, 3'd0);
    cyc(); cyc(); chk("rst_owner1", bus_if.hmaster, 1);
    drive(4'b0010, 4'b0000, 2'd2, 3'd5);
    cyc();
    bus_if.htrans = 2'd3;
    cyc(); cyc(); chk("rst_mid_burst", bus_if.hgrant, 4'b0010);
    #2 hresetn = 1'b0;
    #1 chk("rst_async", {bus_if.hgrant, 2'(bus_if.hmaster), bus_if.hmastlock},
           {4'b0001, 2'd0, 1'b0});
    drive(4'b0100, 4'b0000, 2'd1, 3'd0);
    cyc(); chk("rst_held", bus_if.hgrant, 4'b0001);
    hresetn = 1'b1;
    cyc(); chk("rst_first_grant", bus_if.hgrant, 4'b0100);
    bus_if.htrans = 2'd0;
    cyc(); chk("rst_owner2", bus_if.hmaster, 2);
    drive(4'b0100, 4'b0000, 2'd2, 3'd3);
    cyc(); chk("rst_new_burst", bus_if.hgrant, 4'b0100);
    bus_if.htrans = 2'd0;
    cyc();

    // Randomized traffic, one asynchronous reset in the middle
    rq = '0; lk = '0;
    for (int i = 0; i < 3000; i++) begin
      bus_if.hready = ($urandom_range(0, 4) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, N - 1);
        lk[r] = ~lk[r];
      end
      bus_if.hbusreq = rq;
      bus_if.hlock = lk;
      r = $urandom_range(0, 9);
      if (r == 0)      bus_if.htrans = 2'd0;
      else if (r == 1) bus_if.htrans = 2'd1;
      else if (r < 4) begin
        bus_if.htrans = 2'd2;
        bus_if.hburst = 3'($urandom_range(0, 7));
      end else         bus_if.htrans = 2'd3;
      if (i == 1502) hresetn = 1'b1;
      if (i == 1500) #3 hresetn = 1'b0;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
